vga_sync: RTL and testbench

VGA_SYNC -- requirements
Module: vga_sync

---
 rtl/vga_sync.sv | 139 +++++++++++++
 tb/tb_vga_sync.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
// ---------------------------------------------------------------------------
// vga_sync
//
// Generates VGA raster timing from a single system clock. A clock divider
// produces a one-cycle pixel enable; on every enabled edge the horizontal
// counter advances, and the vertical counter advances when the horizontal
// counter wraps. The visible-area flag, both sync strobes and the end-of-frame
// pulse are decoded from the next-state counter values and registered. As a
// result, they always line up with the coluna/linha values shown in the same
// cycle.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous reset, active low
//   pixel_tick : pixel enable, high for one clk in every DIV_PIXEL
//   coluna     : horizontal position, 0 .. H_TOTAL-1
//   linha      : vertical position, 0 .. V_TOTAL-1
//   areaAtiva  : high while the position is inside the visible area
//   hsync      : horizontal sync, active low
//   vsync      : vertical sync, active low
//   fim_quadro : one-clk pulse on the last pixel of a frame
// ---------------------------------------------------------------------------
module vga_sync #(
  parameter int H_ATIVO   = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ATIVO   = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int DIV_PIXEL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pixel_tick,
  output logic [9:0] coluna,
  output logic [9:0] linha,
  output logic       areaAtiva,
  output logic       hsync,
  output logic       vsync,
  output logic       fim_quadro
);

  // All bounds are held at 10 bits so that every compare below matches the
  // counter width. The sync windows are stored as inclusive first/last
  // values. This keeps each bound representable even when a porch is zero
  // and the total is exactly 1024.
  localparam logic [9:0] H_LAST       = 10'(H_ATIVO + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST       = 10'(V_ATIVO + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS        = 10'(H_ATIVO);
  localparam logic [9:0] V_VIS        = 10'(V_ATIVO);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_ATIVO + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_ATIVO + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_ATIVO + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_ATIVO + V_FRONT + V_SYNC - 1);
  localparam logic [2:0] DIV_LAST     = 3'(DIV_PIXEL - 1);

  logic [2:0] div_q, div_d;
  logic       run_q, run_d;
  logic       pixel_tick_q, pixel_tick_d;
  logic [9:0] coluna_q, coluna_d;
  logic [9:0] linha_q, linha_d;
  logic       area_ativa_q, area_ativa_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       fim_quadro_q, fim_quadro_d;

  // Next-state logic. The first edge after reset release is an alignment
  // edge: the divider stays at 0 (run_q is still clear). Because of this,
  // the first pixel_tick arrives DIV_PIXEL-1 edges later. With DIV_PIXEL=1
  // it arrives on that alignment edge itself. The counters advance on
  // edges where the registered pixel_tick is high. The decoded outputs are
  // computed from the *next* counter values, so that they register in step
  // with the counters.
  always_comb begin
    run_d = 1'b1;

    if (run_q) begin
      div_d = (div_q == DIV_LAST) ? 3'd0 : div_q + 3'd1;
    end else begin
      div_d = 3'd0;
    end

    pixel_tick_d = (div_d == DIV_LAST);

    coluna_d = coluna_q;
    linha_d  = linha_q;
    if (pixel_tick_q) begin
      if (coluna_q == H_LAST) begin
        coluna_d = 10'd0;
        linha_d  = (linha_q == V_LAST) ? 10'd0 : linha_q + 10'd1;
      end else begin
        coluna_d = coluna_q + 10'd1;
      end
    end

    area_ativa_d = (coluna_d < H_VIS) && (linha_d < V_VIS);
    hsync_d      = !((coluna_d >= H_SYNC_FIRST) && (coluna_d <= H_SYNC_LAST));
    vsync_d      = !((linha_d >= V_SYNC_FIRST) && (linha_d <= V_SYNC_LAST));
    fim_quadro_d = pixel_tick_d && (coluna_d == H_LAST) && (linha_d == V_LAST);
  end

  // State registers. Reset clears everything asynchronously, so a reset
  // asserted mid-sync or during the end-of-frame pulse takes effect at once.
  // The sync strobes idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= 3'd0;
      run_q        <= 1'b0;
      pixel_tick_q <= 1'b0;
      coluna_q     <= 10'd0;
      linha_q      <= 10'd0;
      area_ativa_q <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      fim_quadro_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      run_q        <= run_d;
      pixel_tick_q <= pixel_tick_d;
      coluna_q     <= coluna_d;
      linha_q      <= linha_d;
      area_ativa_q <= area_ativa_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      fim_quadro_q <= fim_quadro_d;
    end
  end

  assign pixel_tick = pixel_tick_q;
  assign coluna     = coluna_q;
  assign linha      = linha_q;
  assign areaAtiva  = area_ativa_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign fim_quadro = fim_quadro_q;

endmodule

// File: tb/tb_vga_sync.sv
// ---------------------------------------------------------------------------
// tb_vga_sync
//
// Drives three vga_sync instances from one clock and one reset:
//   dut_def : default 640x480 timing, DIV_PIXEL = 2 (line-level timing)
//   dut_s3  : tiny 15x8 raster, DIV_PIXEL = 3 (whole frames, wrap, vsync)
//   dut_s1  : tiny 15x8 raster, DIV_PIXEL = 1 (tick always high, frame length)
//
// The reference model is closed form. Let k be the number of clk edges
// since reset release, where the first edge is k = 1. The pixel index is
// then (k-1)/DIV, and the position and decodes follow from that index.
// Each clock edge pushes the expected output word into a per-instance
// scoreboard queue. The word is popped and compared on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_sync;

  typedef struct packed {
    logic       tick;
    logic [9:0] col;
    logic [9:0] lin;
    logic       area;
    logic       hs;
    logic       vs;
    logic       fim;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic       d_tick, d_area, d_hs, d_vs, d_fim;
  logic [9:0] d_col, d_lin;
  logic       s3_tick, s3_area, s3_hs, s3_vs, s3_fim;
  logic [9:0] s3_col, s3_lin;
  logic       s1_tick, s1_area, s1_hs, s1_vs, s1_fim;
  logic [9:0] s1_col, s1_lin;

  vga_sync dut_def (
    .clk(clk), .rst_n(rst_n), .pixel_tick(d_tick), .coluna(d_col), .linha(d_lin),
    .areaAtiva(d_area), .hsync(d_hs), .vsync(d_vs), .fim_quadro(d_fim)
  );

  vga_sync #(
    .H_ATIVO(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ATIVO(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .DIV_PIXEL(3)
  ) dut_s3 (
    .clk(clk), .rst_n(rst_n), .pixel_tick(s3_tick), .coluna(s3_col), .linha(s3_lin),
    .areaAtiva(s3_area), .hsync(s3_hs), .vsync(s3_vs), .fim_quadro(s3_fim)
  );

  vga_sync #(
    .H_ATIVO(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ATIVO(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .DIV_PIXEL(1)
  ) dut_s1 (
    .clk(clk), .rst_n(rst_n), .pixel_tick(s1_tick), .coluna(s1_col), .linha(s1_lin),
    .areaAtiva(s1_area), .hsync(s1_hs), .vsync(s1_vs), .fim_quadro(s1_fim)
  );

  logic [24:0] obs_def, obs_s3, obs_s1;
  assign obs_def = {d_tick, d_col, d_lin, d_area, d_hs, d_vs, d_fim};
  assign obs_s3  = {s3_tick, s3_col, s3_lin, s3_area, s3_hs, s3_vs, s3_fim};
  assign obs_s1  = {s1_tick, s1_col, s1_lin, s1_area, s1_hs, s1_vs, s1_fim};

  int   n_checks = 0;
  int   n_fail = 0;
  int   k = 0;
  bit   measure_on = 1'b0;
  exp_t sb_def[$];
  exp_t sb_s3[$];
  exp_t sb_s1[$];

  // Measurements taken from the DUT outputs during the main run
  int def_area_px = 0, def_hs_px = 0, def_line_px = 0, def_ticks = 0, def_fims = 0;
  int def_hs_first = -1, def_hs_last = -1;
  int s3_fims = 0, s3_last_fim = 0, s3_vs_px = 0;
  int s1_fims = 0, s1_last_fim = 0, s1_ticks = 0;
  int bad_area = 0;

  // Expected outputs after edge kk (kk = 0 means reset is still held)
  function automatic exp_t model(input int kk, input int ha, input int hf, input int hs,
                                 input int hb, input int va, input int vf, input int vs,
                                 input int vb, input int dv);
    exp_t e;
    int   p, ht, vt, c, l;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (kk == 0) begin
      e = '{tick: 1'b0, col: 10'd0, lin: 10'd0, area: 1'b0, hs: 1'b1, vs: 1'b1, fim: 1'b0};
      return e;
    end
    p = (kk - 1) / dv;
    c = p % ht;
    l = (p / ht) % vt;
    e.tick = (((kk - 1) % dv) == (dv - 1));
    e.col  = 10'(c);
    e.lin  = 10'(l);
    e.area = (c < ha) && (l < va);
    e.hs   = !((c >= ha + hf) && (c < ha + hf + hs));
    e.vs   = !((l >= va + vf) && (l < va + vf + vs));
    e.fim  = e.tick && (c == ht - 1) && (l == vt - 1);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t k=%0d)", tag, got, want, $time, k);
    end
  endtask

  task automatic measure();
    if (d_tick) def_ticks++;
    if (d_fim) def_fims++;
    if (d_tick && d_lin == 10'd0) begin
      def_line_px++;
      if (d_area) def_area_px++;
      if (!d_hs) begin
        def_hs_px++;
        if (def_hs_first < 0) def_hs_first = int'(d_col);
        def_hs_last = int'(d_col);
      end
    end
    if (s3_fim) begin
      s3_fims++;
      if (s3_last_fim > 0) checkOutput("s3_frame_len", 32'(k - s3_last_fim), 32'd360);
      s3_last_fim = k;
    end
    if (s3_tick && !s3_vs && k <= 360) s3_vs_px++;
    if (s1_tick) s1_ticks++;
    if (s1_fim) begin
      s1_fims++;
      if (s1_last_fim > 0) checkOutput("s1_frame_len", 32'(k - s1_last_fim), 32'd120);
      s1_last_fim = k;
    end
    if (d_area && d_lin >= 10'd480) bad_area++;
    if (s3_area && s3_lin >= 10'd4) bad_area++;
    if (s1_area && s1_lin >= 10'd4) bad_area++;
  endtask

  // One clk per iteration: queue expectations at the rising edge, check them
  // at the falling edge.
  task automatic applyStimulus(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      if (rst_n) k++;
      sb_def.push_back(model(k, 640, 16, 96, 48, 480, 10, 2, 33, 2));
      sb_s3.push_back(model(k, 8, 2, 3, 2, 4, 1, 2, 1, 3));
      sb_s1.push_back(model(k, 8, 2, 3, 2, 4, 1, 2, 1, 1));
      @(negedge clk);
      e = sb_def.pop_front();
      checkOutput("def", {7'd0, obs_def}, {7'd0, e});
      e = sb_s3.pop_front();
      checkOutput("s3", {7'd0, obs_s3}, {7'd0, e});
      e = sb_s1.pop_front();
      checkOutput("s1", {7'd0, obs_s1}, {7'd0, e});
      if (measure_on) measure();
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t r;
    bit   found;
    r = model(0, 8, 2, 3, 2, 4, 1, 2, 1, 1);

    $display("[TB] reset phase");
    applyStimulus(3);

    $display("[TB] main run");
    rst_n = 1'b1;
    measure_on = 1'b1;
    applyStimulus(3500);
    measure_on = 1'b0;

    checkOutput("def_ticks", 32'(def_ticks), 32'd1750);
    checkOutput("def_line0_px", 32'(def_line_px), 32'd800);
    checkOutput("def_area_px", 32'(def_area_px), 32'd640);
    checkOutput("def_hs_px", 32'(def_hs_px), 32'd96);
    checkOutput("def_hs_first", 32'(def_hs_first), 32'd656);
    checkOutput("def_hs_last", 32'(def_hs_last), 32'd751);
    checkOutput("def_no_fim", 32'(def_fims), 32'd0);
    checkOutput("s3_fims", 32'(s3_fims), 32'd9);
    checkOutput("s3_vs_px", 32'(s3_vs_px), 32'd30);
    checkOutput("s1_fims", 32'(s1_fims), 32'd29);
    checkOutput("s1_ticks", 32'(s1_ticks), 32'd3500);
    checkOutput("area_outside", 32'(bad_area), 32'd0);

    $display("[TB] async reset at coluna 700");
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(1);
      if (d_col == 10'd700) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("reach_col700", 32'(found), 32'd1);
    checkOutput("hsync_low_700", 32'(d_hs), 32'd0);

    #2;
    rst_n = 1'b0;
    k = 0;
    #1;
    checkOutput("async_rst_def", {7'd0, obs_def}, {7'd0, r});
    checkOutput("async_rst_s3", {7'd0, obs_s3}, {7'd0, r});
    checkOutput("async_rst_s1", {7'd0, obs_s1}, {7'd0, r});

    applyStimulus(2);
    rst_n = 1'b1;
    applyStimulus(1);
    checkOutput("post_rst_area", 32'(d_area), 32'd1);
    checkOutput("post_rst_col", 32'(d_col), 32'd0);
    checkOutput("post_rst_hs_vs", 32'({d_hs, d_vs}), 32'd3);
    checkOutput("post_rst_tick", 32'(d_tick), 32'd0);
    applyStimulus(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
